// File: rtl/result_row_collector_pkg.sv
// Shared types and constants for the result row collector: state encoding,
// tag width and a constant ceil(log2) helper used for result widths.
package result_row_collector_pkg;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_STALL   = 1'b1
    } state_t;

    localparam int TAG_W = 16;

    // Ceil(log2(value)); returns 0 for value <= 1 so DIM==1 adds no result bits.
    function automatic int clogb2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/result_row_collector_slot.sv
// One collect-buffer slot: a RES_WIDTH register with async active-low clear
// and a load enable.
module result_slot_reg #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_r;

    // Slot storage, written only when the collector selects this slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r <= '0;
        end else if (load) begin
            q_r <= d;
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/result_row_collector.sv
// Gathers DIM scalar results into one packed row and offers it on valid/ready.
// Optional row sequence tag output enabled by RESULT_ROW_COLLECTOR_TAG_EN.
module result_row_collector
    import result_row_collector_pkg::*;
#(
    parameter  int DIM       = 2,
    parameter  int W_u       = 32,
    localparam int RES_WIDTH = W_u + clogb2(DIM),
    localparam int IDX_W     = clogb2(DIM) + 1
) (
    input  logic                     Clock,
    input  logic                     Resetn,
    input  logic [RES_WIDTH-1:0]     sum,
    input  logic                     readEn,
    output logic [DIM*RES_WIDTH-1:0] out_vec,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     overflow,
    output logic [IDX_W-1:0]         idx_dbg
`ifdef RESULT_ROW_COLLECTOR_TAG_EN
    ,
    output logic [TAG_W-1:0]         out_tag
`endif
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIM - 1);

    state_t                   state_r;
    state_t                   state_nxt_s;
    logic [IDX_W-1:0]         idx_r;
    logic [IDX_W-1:0]         idx_nxt_s;
    logic [DIM*RES_WIDTH-1:0] out_vec_r;
    logic                     out_valid_r;
    logic                     overflow_r;
    logic [DIM-1:0]           slot_load_s;
    logic [DIM*RES_WIDTH-1:0] collect_vec_s;
    logic [DIM*RES_WIDTH-1:0] out_src_s;
    logic                     load_out_s;
    logic                     ovf_set_s;
    logic                     free_s;

    genvar k;
    generate
        for (k = 0; k < DIM; k++) begin : g_slot
            result_slot_reg #(.W(RES_WIDTH)) u_slot (
                .clk   (Clock),
                .rst_n (Resetn),
                .load  (slot_load_s[k]),
                .d     (sum),
                .q     (collect_vec_s[RES_WIDTH*k +: RES_WIDTH])
            );
        end
    endgenerate

    assign free_s = !out_valid_r || out_ready;

    // Next-state, slot write enables and output-register load selection.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        slot_load_s = '0;
        load_out_s  = 1'b0;
        ovf_set_s   = 1'b0;
        out_src_s   = collect_vec_s;
        case (state_r)
            ST_COLLECT: begin
                if (readEn) begin
                    if (idx_r != LAST_IDX) begin
                        slot_load_s = DIM'(1) << idx_r;
                        idx_nxt_s   = idx_r + IDX_W'(1);
                    end else if (free_s) begin
                        // Final result goes straight into the output row.
                        load_out_s = 1'b1;
                        out_src_s[RES_WIDTH*(DIM-1) +: RES_WIDTH] = sum;
                        idx_nxt_s  = '0;
                    end else begin
                        slot_load_s[DIM-1] = 1'b1;
                        state_nxt_s        = ST_STALL;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_STALL: begin
                if (free_s) begin
                    load_out_s  = 1'b1;
                    idx_nxt_s   = '0;
                    state_nxt_s = ST_COLLECT;
                end else begin
                    state_nxt_s = ST_STALL;
                end
                // No bypass: any strobe here has nowhere to go.
                if (readEn) begin
                    ovf_set_s = 1'b1;
                end else begin
                    ovf_set_s = 1'b0;
                end
            end
            default: begin
                state_nxt_s = ST_COLLECT;
                idx_nxt_s   = '0;
            end
        endcase
    end

    // FSM, fill index, output register and sticky overflow.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_r     <= ST_COLLECT;
            idx_r       <= '0;
            out_vec_r   <= '0;
            out_valid_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            idx_r      <= idx_nxt_s;
            overflow_r <= overflow_r | ovf_set_s;
            if (load_out_s) begin
                out_vec_r   <= out_src_s;
                out_valid_r <= 1'b1;
            end else if (out_ready) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
        end
    end

`ifdef RESULT_ROW_COLLECTOR_TAG_EN
    logic [TAG_W-1:0] tag_r;

    // Row sequence number, advanced on every accepted transfer.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            tag_r <= '0;
        end else if (out_valid_r && out_ready) begin
            tag_r <= tag_r + 16'd1;
        end else begin
            tag_r <= tag_r;
        end
    end

    assign out_tag = tag_r;
`endif

    assign out_vec   = out_vec_r;
    assign out_valid = out_valid_r;
    assign overflow  = overflow_r;
    assign idx_dbg   = idx_r;

endmodule

// File: tb/tb_result_row_collector.sv
// Directed self-checking bench for result_row_collector with DIM=2, W_u=32.
module tb_result_row_collector;

    localparam int RW = 33;

    logic          Clock;
    logic          Resetn;
    logic [RW-1:0] sum;
    logic          readEn;
    logic [2*RW-1:0] out_vec;
    logic          out_valid;
    logic          out_ready;
    logic          overflow;
    logic [1:0]    idx_dbg;
`ifdef RESULT_ROW_COLLECTOR_TAG_EN
    logic [15:0]   out_tag;
`endif

    int total = 0;
    int bad   = 0;

    result_row_collector #(.DIM(2), .W_u(32)) dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .sum       (sum),
        .readEn    (readEn),
        .out_vec   (out_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow),
        .idx_dbg   (idx_dbg)
`ifdef RESULT_ROW_COLLECTOR_TAG_EN
        ,
        .out_tag   (out_tag)
`endif
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [2*RW-1:0] obs, input logic [2*RW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    function automatic logic [2*RW-1:0] row(input int s0, input int s1);
        return {RW'(s1), RW'(s0)};
    endfunction

    task automatic check_tag(input string tag, input int exp);
`ifdef RESULT_ROW_COLLECTOR_TAG_EN
        check(tag, 66'(out_tag), 66'(exp));
`endif
    endtask

    initial begin
        Resetn = 1'b0; sum = '0; readEn = 1'b0; out_ready = 1'b1;
        #12;
        check("rst_vec", out_vec, 66'd0);
        check("rst_valid", 66'(out_valid), 66'd0);
        check("rst_ovf", 66'(overflow), 66'd0);
        check("rst_idx", 66'(idx_dbg), 66'd0);
        check_tag("rst_tag", 0);
        Resetn = 1'b1;
        tick();

        // Basic row 5,7.
        readEn = 1'b1; sum = 33'd5; tick();
        check("basic_idx1", 66'(idx_dbg), 66'd1);
        check("basic_nv", 66'(out_valid), 66'd0);
        sum = 33'd7; tick();
        readEn = 1'b0;
        check("basic_valid", 66'(out_valid), 66'd1);
        check("basic_vec", out_vec, row(5, 7));
        check("basic_idx0", 66'(idx_dbg), 66'd0);
        check_tag("basic_tag", 0);
        tick();
        check("basic_drop_valid", 66'(out_valid), 66'd0);
        check("basic_ovf", 66'(overflow), 66'd0);

        // Back-to-back 1,2,3,4.
        readEn = 1'b1; sum = 33'd1; tick();
        sum = 33'd2; tick();
        check("b2b_v1", 66'(out_valid), 66'd1);
        check("b2b_vec1", out_vec, row(1, 2));
        check_tag("b2b_tag1", 1);
        sum = 33'd3; tick();
        check("b2b_gap", 66'(out_valid), 66'd0);
        sum = 33'd4; tick();
        readEn = 1'b0;
        check("b2b_v2", 66'(out_valid), 66'd1);
        check("b2b_vec2", out_vec, row(3, 4));
        check_tag("b2b_tag2", 2);
        tick();
        check("b2b_end", 66'(out_valid), 66'd0);

        // Backpressure: rows {1,2} and {3,4} with out_ready low.
        out_ready = 1'b0;
        readEn = 1'b1; sum = 33'd1; tick();
        sum = 33'd2; tick();
        check("bp_vec1", out_vec, row(1, 2));
        sum = 33'd3; tick();
        sum = 33'd4; tick();
        readEn = 1'b0;
        check("bp_idx_stall", 66'(idx_dbg), 66'd1);
        check("bp_valid_hold", 66'(out_valid), 66'd1);
        tick();
        check("bp_vec_stable", out_vec, row(1, 2));
        check_tag("bp_tag_hold", 3);

        // Strobe while stalled is dropped and flagged.
        readEn = 1'b1; sum = 33'd9; tick();
        readEn = 1'b0;
        check("ovf_set", 66'(overflow), 66'd1);
        check("ovf_vec", out_vec, row(1, 2));

        out_ready = 1'b1; tick();
        check("bp_vec2", out_vec, row(3, 4));
        check("bp_valid2", 66'(out_valid), 66'd1);
        check("bp_idx0", 66'(idx_dbg), 66'd0);
        check_tag("bp_tag2", 4);
        tick();
        check("bp_drain", 66'(out_valid), 66'd0);

        // Later row still succeeds; overflow stays sticky.
        readEn = 1'b1; sum = 33'd10; tick();
        sum = 33'd11; tick();
        readEn = 1'b0;
        check("post_vec", out_vec, row(10, 11));
        check("ovf_sticky", 66'(overflow), 66'd1);
        check_tag("post_tag", 5);
        tick();

        // Async reset mid-row.
        readEn = 1'b1; sum = 33'd5; tick();
        readEn = 1'b0;
        check("mid_idx", 66'(idx_dbg), 66'd1);
        #2 Resetn = 1'b0;
        #1;
        check("ar_vec", out_vec, 66'd0);
        check("ar_valid", 66'(out_valid), 66'd0);
        check("ar_ovf", 66'(overflow), 66'd0);
        check("ar_idx", 66'(idx_dbg), 66'd0);
        check_tag("ar_tag", 0);
        Resetn = 1'b1;
        tick();
        readEn = 1'b1; sum = 33'd8; tick();
        sum = 33'd6; tick();
        readEn = 1'b0;
        check("ar_row_vec", out_vec, row(8, 6));
        check("ar_row_valid", 66'(out_valid), 66'd1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
